// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, exception code, load-type and FSM encodings shared by the memory stage.
package mem_stage_pkg;
    localparam int ES_TO_MS_BUS_WD = 123;
    localparam int MS_TO_WS_BUS_WD = 117;
    localparam logic [4:0] NO_EX = 5'h1f;
    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_B    = 3'b001;
    localparam logic [2:0] LD_BU   = 3'b010;
    localparam logic [2:0] LD_H    = 3'b011;
    localparam logic [2:0] LD_HU   = 3'b100;
    localparam logic [2:0] LD_W    = 3'b101;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;
endpackage

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: selects the addressed byte/half of a load word and sign/zero extends it.
module mem_stage_load_align import mem_stage_pkg::*; (
    input  logic [2:0]  ld_type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pass_i,
    output logic [31:0] result_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    assign byte_sel = data_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
    // Encodings 11x fall through to the full-word case.
    always_comb begin
        result_o = ld_type_i == LD_NONE ? pass_i
                 : ld_type_i == LD_B    ? {{24{byte_sel[7]}}, byte_sel}
                 : ld_type_i == LD_BU   ? {24'd0, byte_sel}
                 : ld_type_i == LD_H    ? {{16{half_sel[15]}}, half_sel}
                 : ld_type_i == LD_HU   ? {16'd0, half_sel}
                 : data_i;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage; waits for data SRAM responses, aligns load data and
// discards responses whose instruction was flushed by write-back.
module mem_stage import mem_stage_pkg::*; (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ws_flush,
    output logic [4:0]                 MEM_dest,
    output logic [31:0]                MEM_dest_data,
    output logic                       ms_load_stall,
    output logic                       ms_inst_mfc0,
    output logic                       MS_EX,
    output logic                       ms_drop_busy
);
    state_e                     state_q, state_d;
    logic                       ms_valid_q, ms_valid_d;
    logic                       buf_valid_q, buf_valid_d;
    logic [31:0]                buf_q;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q;
    logic [2:0]                 ld_type;
    logic                       req_sent;
    logic [1:0]                 addr_lo;
    logic [MS_TO_WS_BUS_WD-1:0] wb;
    logic                       rsp, ready_go, capture, leave;
    logic [31:0]                final_result;

    assign ld_type  = bus_q[122:120];
    assign req_sent = bus_q[119];
    assign addr_lo  = bus_q[118:117];
    assign wb       = bus_q[116:0];
    // Only a response in WAIT belongs to the resident instruction; stray ones are ignored.
    assign rsp      = data_sram_data_ok && state_q == S_WAIT;
    assign capture  = ms_allowin && es_to_ms_valid;
    assign leave    = ms_to_ws_valid && ws_allowin;

    mem_stage_load_align u_align (
        .ld_type_i (ld_type),
        .addr_lo_i (addr_lo),
        .data_i    (buf_valid_q ? buf_q : data_sram_rdata),
        .pass_i    (wb[63:32]),
        .result_o  (final_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ms_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            bus_q       <= '0;
        end else begin
            state_q     <= state_d;
            ms_valid_q  <= ms_valid_d;
            buf_valid_q <= buf_valid_d;
            if (rsp && !ws_allowin) buf_q <= data_sram_rdata;
            if (capture) bus_q <= es_to_ms_bus;
        end
    end

    always_comb begin
        state_d = state_q == S_IDLE ? (capture && !ws_flush && es_to_ms_bus[119] ? S_WAIT : S_IDLE)
                : state_q == S_WAIT ? (ws_flush ? (rsp ? S_IDLE : S_DROP)
                                     : leave ? (capture && es_to_ms_bus[119] ? S_WAIT : S_IDLE)
                                     : S_WAIT)
                : (data_sram_data_ok ? S_IDLE : S_DROP);
    end

    always_comb begin
        ready_go       = !(ms_valid_q && req_sent) || rsp || buf_valid_q;
        ms_allowin     = (!ms_valid_q || (ready_go && ws_allowin)) && state_q != S_DROP;
        ms_to_ws_valid = ms_valid_q && ready_go && !ws_flush;
        ms_valid_d     = ws_flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid_q;
        buf_valid_d    = (ws_flush || leave) ? 1'b0 : (rsp && !ws_allowin) ? 1'b1 : buf_valid_q;
        ms_to_ws_bus   = {wb[116:64], final_result, wb[31:0]};
        MEM_dest       = ms_valid_q ? wb[68:64] : 5'd0;
        MEM_dest_data  = final_result;
        ms_load_stall  = ms_valid_q && ld_type != LD_NONE && !(rsp || buf_valid_q);
        ms_inst_mfc0   = ms_valid_q && wb[111];
        MS_EX          = ms_valid_q && wb[76:72] != NO_EX;
        ms_drop_busy   = state_q == S_DROP;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a write-back scoreboard for the memory stage.
module tb_mem_stage;
    import mem_stage_pkg::*;
    logic         clk = 1'b0;
    logic         reset, es_to_ms_valid, ws_allowin, data_sram_data_ok, ws_flush;
    logic [122:0] es_to_ms_bus;
    logic [31:0]  data_sram_rdata;
    logic         ms_allowin, ms_to_ws_valid, ms_load_stall, ms_inst_mfc0, MS_EX, ms_drop_busy;
    logic [116:0] ms_to_ws_bus;
    logic [4:0]   MEM_dest;
    logic [31:0]  MEM_dest_data;
    logic [116:0] sb[$];
    logic [122:0] b, b2;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
        .es_to_ms_bus(es_to_ms_bus), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_to_ws_bus(ms_to_ws_bus), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ws_flush(ws_flush), .MEM_dest(MEM_dest),
        .MEM_dest_data(MEM_dest_data), .ms_load_stall(ms_load_stall), .ms_inst_mfc0(ms_inst_mfc0),
        .MS_EX(MS_EX), .ms_drop_busy(ms_drop_busy)
    );

    function automatic logic [122:0] mk(input logic [2:0] ld, input logic rs, input logic [1:0] alo,
                                        input logic [4:0] dest, input logic [31:0] res,
                                        input logic [31:0] pc, input logic [4:0] ex);
        return {ld, rs, alo, 5'd0, 3'b000, 32'd0, ex, 3'b001, dest, res, pc};
    endfunction

    function automatic logic [116:0] exp_wb(input logic [122:0] in, input logic [31:0] res);
        return {in[116:64], res, in[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [116:0] obs, input logic [116:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic ev, input logic [122:0] bus, input logic dok,
                       input logic [31:0] rd, input logic wa, input logic fl);
        es_to_ms_valid = ev; es_to_ms_bus = bus; data_sram_data_ok = dok;
        data_sram_rdata = rd; ws_allowin = wa; ws_flush = fl;
        #1;
    endtask

    task automatic tick();
        if (ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) chk("unexpected_wb", {116'd0, ms_to_ws_valid}, 117'd0);
            else chk("wb_bus", ms_to_ws_bus, sb.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        cyc(0, '0, 0, 0, 1, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        cyc(0, '0, 0, 0, 1, 0);
        chk("rst_allowin", {116'd0, ms_allowin}, 117'd1);
        chk("rst_valid", {116'd0, ms_to_ws_valid}, 117'd0);
        chk("rst_bus", ms_to_ws_bus, 117'd0);
        chk("rst_dest", {112'd0, MEM_dest}, 117'd0);
        chk("rst_dest_data", {85'd0, MEM_dest_data}, 117'd0);
        chk("rst_flags", {112'd0, ms_load_stall, ms_inst_mfc0, MS_EX, ms_drop_busy, 1'b0}, 117'd0);
        tick();
        // ALU instruction passes in one cycle
        b = mk(LD_NONE, 0, 0, 5, 32'h1234, 32'hbfc0_0100, NO_EX);
        cyc(1, b, 0, 0, 1, 0); sb.push_back(exp_wb(b, 32'h1234)); tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("alu_valid", {116'd0, ms_to_ws_valid}, 117'd1);
        chk("alu_dest", {112'd0, MEM_dest}, 117'd5);
        chk("alu_data", {85'd0, MEM_dest_data}, 117'h1234);
        chk("alu_ms_ex", {116'd0, MS_EX}, 117'd0);
        tick();
        b = mk(LD_NONE, 0, 0, 7, 32'h55, 32'hbfc0_0104, 5'h04);
        cyc(1, b, 0, 0, 1, 0); sb.push_back(exp_wb(b, 32'h55)); tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("ex_ms_ex", {116'd0, MS_EX}, 117'd1);
        tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("idle_dest", {112'd0, MEM_dest}, 117'd0);
        tick();
        // lb, byte 2, negative
        b = mk(LD_B, 1, 2, 9, 32'hdead, 32'hbfc0_0108, NO_EX);
        cyc(1, b, 0, 0, 1, 0); sb.push_back(exp_wb(b, 32'hffff_ff80)); tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("lb_stall1", {116'd0, ms_load_stall}, 117'd1);
        chk("lb_wait_valid", {116'd0, ms_to_ws_valid}, 117'd0);
        chk("lb_wait_allowin", {116'd0, ms_allowin}, 117'd0);
        tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("lb_stall2", {116'd0, ms_load_stall}, 117'd1);
        tick();
        cyc(0, '0, 1, 32'h1180_2233, 1, 0);
        chk("lb_valid", {116'd0, ms_to_ws_valid}, 117'd1);
        chk("lb_data", {85'd0, MEM_dest_data}, 117'hffff_ff80);
        chk("lb_stall_ok", {116'd0, ms_load_stall}, 117'd0);
        chk("lb_allowin", {116'd0, ms_allowin}, 117'd1);
        tick();
        // lhu with response buffered while write-back is blocked
        b = mk(LD_HU, 1, 2, 10, 0, 32'hbfc0_010c, NO_EX);
        cyc(1, b, 0, 0, 1, 0); sb.push_back(exp_wb(b, 32'h0000_8001)); tick();
        cyc(0, '0, 0, 0, 1, 0); tick();
        cyc(0, '0, 1, 32'h8001_0000, 0, 0);
        chk("lhu_valid_blocked", {116'd0, ms_to_ws_valid}, 117'd1);
        chk("lhu_allowin_blocked", {116'd0, ms_allowin}, 117'd0);
        tick();
        cyc(0, '0, 0, 32'hffff_ffff, 0, 0);
        chk("lhu_buf_valid", {116'd0, ms_to_ws_valid}, 117'd1);
        chk("lhu_buf_data", {85'd0, MEM_dest_data}, 117'h8001);
        chk("lhu_buf_stall", {116'd0, ms_load_stall}, 117'd0);
        tick();
        cyc(0, '0, 0, 32'hffff_ffff, 0, 0); tick();
        cyc(0, '0, 0, 32'hffff_ffff, 1, 0);
        chk("lhu_release", {85'd0, MEM_dest_data}, 117'h8001);
        tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("lhu_gone", {116'd0, ms_to_ws_valid}, 117'd0);
        tick();
        // back-to-back lw then lh
        b = mk(LD_W, 1, 0, 11, 0, 32'hbfc0_0110, NO_EX);
        b2 = mk(LD_H, 1, 0, 12, 0, 32'hbfc0_0114, NO_EX);
        cyc(1, b, 0, 0, 1, 0); sb.push_back(exp_wb(b, 32'hcafe_f00d)); tick();
        cyc(0, '0, 0, 0, 1, 0); tick();
        cyc(1, b2, 1, 32'hcafe_f00d, 1, 0);
        chk("b2b_allowin", {116'd0, ms_allowin}, 117'd1);
        chk("lw_data", {85'd0, MEM_dest_data}, 117'hcafe_f00d);
        sb.push_back(exp_wb(b2, 32'hffff_8765)); tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("b2b_stall", {116'd0, ms_load_stall}, 117'd1);
        chk("b2b_dest", {112'd0, MEM_dest}, 117'd12);
        tick();
        cyc(0, '0, 1, 32'h1234_8765, 1, 0);
        chk("lh_data", {85'd0, MEM_dest_data}, 117'hffff_8765);
        tick();
        // store waits for data_ok, result unchanged
        b = mk(LD_NONE, 1, 0, 0, 32'h77, 32'hbfc0_0118, NO_EX);
        cyc(1, b, 0, 0, 1, 0); sb.push_back(exp_wb(b, 32'h77)); tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("st_wait_valid", {116'd0, ms_to_ws_valid}, 117'd0);
        chk("st_no_stall", {116'd0, ms_load_stall}, 117'd0);
        tick();
        cyc(0, '0, 1, 32'h9999, 1, 0);
        chk("st_data", {85'd0, MEM_dest_data}, 117'h77);
        tick();
        // flush in WAIT, response arrives later and is dropped
        b = mk(LD_W, 1, 0, 13, 0, 32'hbfc0_011c, NO_EX);
        cyc(1, b, 0, 0, 1, 0); tick();
        cyc(0, '0, 0, 0, 1, 1);
        chk("fl_valid", {116'd0, ms_to_ws_valid}, 117'd0);
        tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("drop_busy1", {116'd0, ms_drop_busy}, 117'd1);
        chk("drop_allowin", {116'd0, ms_allowin}, 117'd0);
        tick();
        cyc(0, '0, 1, 32'h1111, 1, 0);
        chk("drop_busy2", {116'd0, ms_drop_busy}, 117'd1);
        chk("drop_valid", {116'd0, ms_to_ws_valid}, 117'd0);
        tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("drop_done_busy", {116'd0, ms_drop_busy}, 117'd0);
        chk("drop_done_allowin", {116'd0, ms_allowin}, 117'd1);
        tick();
        // flush with same-cycle response goes straight to IDLE
        b = mk(LD_W, 1, 0, 14, 0, 32'hbfc0_0120, NO_EX);
        cyc(1, b, 0, 0, 1, 0); tick();
        cyc(0, '0, 0, 0, 1, 0); tick();
        cyc(0, '0, 1, 32'h2222, 1, 1);
        chk("flok_valid", {116'd0, ms_to_ws_valid}, 117'd0);
        tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("flok_busy", {116'd0, ms_drop_busy}, 117'd0);
        chk("flok_allowin", {116'd0, ms_allowin}, 117'd1);
        tick();
        // reset while waiting, stray response afterwards
        b = mk(LD_W, 1, 0, 15, 0, 32'hbfc0_0124, NO_EX);
        cyc(1, b, 0, 0, 1, 0); tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("rw_stall", {116'd0, ms_load_stall}, 117'd1);
        tick();
        reset = 1'b1;
        cyc(0, '0, 0, 0, 1, 0); tick();
        reset = 1'b0;
        cyc(0, '0, 0, 0, 1, 0);
        chk("rw_valid", {116'd0, ms_to_ws_valid}, 117'd0);
        chk("rw_allowin", {116'd0, ms_allowin}, 117'd1);
        chk("rw_dest", {112'd0, MEM_dest}, 117'd0);
        chk("rw_stall0", {116'd0, ms_load_stall}, 117'd0);
        chk("rw_bus", ms_to_ws_bus, 117'd0);
        tick();
        cyc(0, '0, 1, 32'h3333, 1, 0);
        chk("stray_valid", {116'd0, ms_to_ws_valid}, 117'd0);
        chk("stray_busy", {116'd0, ms_drop_busy}, 117'd0);
        tick();
        cyc(0, '0, 0, 0, 1, 0);
        chk("stray_allowin", {116'd0, ms_allowin}, 117'd1);
        tick();
        chk("sb_empty", 117'(sb.size()), 117'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth stage of the five-stage MIPS pipeline, between the execute stage and `wb_stage`. Holds one instruction per cycle. Waits for the data SRAM response of loads issued by the execute stage, aligns and extends load data, and forwards the result. Drops in-flight work when write-back raises an exception or ERET, and swallows orphaned SRAM responses.

## Interface
- `ES_TO_MS_BUS_WD`, 123, `mycpu.h` macro, width of the input bus
- `MS_TO_WS_BUS_WD`, 117, `mycpu.h` macro, width of the output bus
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `ms_allowin`  out  1  stage can accept from execute this cycle
- `es_to_ms_valid`  in  1  execute presents an instruction
- `es_to_ms_bus`  in  123  [122:120] ld_type (000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, 11x treated as lw), [119] req_sent, [118:117] addr_lo, [116:0] write-back field layout
- `ws_allowin`  in  1  write-back can accept
- `ms_to_ws_valid`  out  1  result valid toward write-back
- `ms_to_ws_bus`  out  117  [116:112] rd, [111] mfc0, [110] mtc0, [109] pc_error, [108:77] BadVAddr, [76:72] ex_code, [71] eret, [70] slot, [69] gr_we, [68:64] dest, [63:32] result, [31:0] pc
- `data_sram_data_ok`  in  1  one-cycle read/write response strobe
- `data_sram_rdata`  in  32  read data, valid with `data_ok`
- `ws_flush`  in  1  `WS_EX | ERET` from write-back
- `MEM_dest`  out  5  dest gated by `ms_valid`, 0 when idle
- `MEM_dest_data`  out  32  forwarded final result
- `ms_load_stall`  out  1  valid load whose data is not yet available (decode must stall on match)
- `ms_inst_mfc0`  out  1  valid mfc0 in stage
- `MS_EX`  out  1  `ms_valid` and ex_code ≠ `NO_EX` (execute suppresses new store requests)
- `ms_drop_busy`  out  1  orphaned response pending; execute must not issue

## Operation
- Pipeline register: on `ms_allowin && es_to_ms_valid` capture bus. `ms_valid <= es_to_ms_valid` when `ms_allowin`.
- `ms_allowin = (!ms_valid || (ms_ready_go && ws_allowin)) && state != DROP`.
- `need_data = req_sent && ms_valid`. `ms_ready_go = !need_data || data_ok || buf_valid`.
- `ms_to_ws_valid = ms_valid && ms_ready_go && !ws_flush`.
- Response buffer: if `data_ok` arrives in WAIT and `ws_allowin` is 0, latch `rdata` into `buf`, set `buf_valid`. Clear it when the entry leaves.
- Load data `d = buf_valid ? buf : rdata`. lb/lbu select byte `addr_lo`, sign/zero extend. lh/lhu select half `addr_lo[1]`, sign/zero extend. lw passes through. Other types pass the incoming result field. Stores still wait for `data_ok`; their result is unchanged.
- FSM:
  - IDLE → WAIT when a `req_sent` entry is captured.
  - WAIT → IDLE on entry leaving.
  - WAIT → DROP on `ws_flush` without same-cycle `data_ok`.
  - WAIT + flush + `data_ok` → IDLE, data discarded.
  - DROP → IDLE on `data_ok`, data discarded.
- `ws_flush`: `ms_valid <= 0`, `buf_valid <= 0` next edge, irrespective of allowin.
- `ms_load_stall = ms_valid && ld_type≠0 && !(data_ok || buf_valid)`. `ms_drop_busy = (state == DROP)`.

## Timing
- Reset: `ms_valid` 0, state IDLE, `buf_valid` 0, bus register 0. All outputs 0 (`ms_allowin` 1).
- Non-memory instruction: 1 cycle in stage.
- Load/store: leaves in the `data_ok` cycle at the earliest; zero added latency after the response.
- Back-to-back loads: next entry may be captured in the cycle the current one leaves.
- Reset mid-WAIT or mid-DROP returns to IDLE. Any later stray `data_ok` in IDLE is ignored.

## Structure
- `ld_type` encodings, FSM state encodings and bus widths go in `mycpu.h` alongside `NO_EX`.
- One sub-module is natural: `load_align` (combinational byte/half select and extend).

## Test plan
- ALU instruction: result 0x1234 to dest 5 → `ms_to_ws_valid` next cycle, `MEM_dest` = 5, `MEM_dest_data` = 0x1234.
- lb with addr_lo = 2, `data_ok` 3 cycles later with rdata = 0x11_80_22_33 → result 0xFFFFFF80. `ms_load_stall` is 1 for the two wait cycles.
- lhu with addr_lo = 2, rdata = 0x8001_0000, `ws_allowin` low for 2 cycles after `data_ok` → buffered result 0x00008001 emitted once `ws_allowin` rises.
- `ws_flush` in WAIT, `data_ok` 2 cycles later → state DROP, `ms_allowin` = 0 and `ms_drop_busy` = 1 until `data_ok`, no write-back valid, then IDLE.
- `ws_flush` and `data_ok` in the same cycle → IDLE directly, `ms_drop_busy` never asserts.
- Reset asserted in WAIT → all outputs 0 next cycle. A following `data_ok` produces no valid.
